// File: rtl/sfx_scheduler_if.sv
`default_nettype none
// =============================================================================
// Module  : sfx_scheduler_if
// Brief   : Event-request / tone-control bundle between game logic and the
//           sound-effect scheduler.
// Rev     : 1.0  initial release
// =============================================================================
interface sfx_scheduler_if;
   logic [2:0]  req;
   logic [31:0] freq;
   logic        note_valid;
   logic        busy;
   logic [1:0]  active_id;
   logic        done;

   modport master (
      output req,
      input  freq, note_valid, busy, active_id, done
   );

   modport slave (
      input  req,
      output freq, note_valid, busy, active_id, done
   );
endinterface
`default_nettype wire

// File: rtl/sfx_scheduler.sv
`default_nettype none
// =============================================================================
// Module  : sfx_scheduler
// Brief   : Fixed-priority, preemptive sound-effect sequencer driving the tone
//           generator frequency (hit / miss / game-over note sequences).
// Rev     : 1.0  initial release
// =============================================================================
module sfx_scheduler #(
   parameter int MS_CYCLES   = 100_000,
   parameter int SILENT_FREQ = 20000
) (
   input  wire               clk,
   input  wire               reset,
   sfx_scheduler_if.slave    bus
);

   localparam int              c_MSW     = (MS_CYCLES > 1) ? $clog2(MS_CYCLES) : 1;
   localparam logic [c_MSW-1:0] c_MS_LAST = c_MSW'(MS_CYCLES - 1);
   localparam logic [31:0]     c_SILENT  = 32'(SILENT_FREQ);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_LOAD = 2'd1,
      S_PLAY = 2'd2
   } state_t;

   state_t           r_state, w_state_nxt;
   logic [1:0]       r_id, w_id_nxt;
   logic [1:0]       r_idx, w_idx_nxt;
   logic [c_MSW-1:0] r_ms, w_ms_nxt;
   logic [8:0]       r_dur, w_dur_nxt;
   logic [31:0]      r_freq, w_freq_nxt;
   logic             r_nv, w_nv_nxt;
   logic             r_busy, w_busy_nxt;
   logic             r_done, w_done_nxt;

   logic [1:0]       w_win;
   logic             w_preempt;
   logic [31:0]      w_rom_freq;
   logic [8:0]       w_rom_dur;
   logic [1:0]       w_last_idx;
   logic [8:0]       w_dur_inc;

   // Note ROM: {frequency Hz, duration ms} indexed by sequence id and note.
   always_comb begin
      w_rom_freq = c_SILENT;
      w_rom_dur  = 9'd1;
      case ({r_id, r_idx})
         4'b00_00: begin w_rom_freq = 32'd1048; w_rom_dur = 9'd100; end
         4'b00_01: begin w_rom_freq = 32'd1318; w_rom_dur = 9'd100; end
         4'b01_00: begin w_rom_freq = 32'd392;  w_rom_dur = 9'd150; end
         4'b01_01: begin w_rom_freq = 32'd262;  w_rom_dur = 9'd250; end
         4'b10_00: begin w_rom_freq = 32'd523;  w_rom_dur = 9'd300; end
         4'b10_01: begin w_rom_freq = 32'd392;  w_rom_dur = 9'd300; end
         4'b10_10: begin w_rom_freq = 32'd330;  w_rom_dur = 9'd300; end
         4'b10_11: begin w_rom_freq = 32'd262;  w_rom_dur = 9'd300; end
         default:  begin w_rom_freq = c_SILENT; w_rom_dur = 9'd1;   end
      endcase
   end

   assign w_last_idx = (r_id == 2'd2) ? 2'd3 : 2'd1;
   assign w_dur_inc  = r_dur + 9'd1;

   // Sequence id doubles as priority: larger id wins.
   assign w_win     = bus.req[2] ? 2'd2 : (bus.req[1] ? 2'd1 : 2'd0);
   assign w_preempt = (r_state != S_IDLE) && (|bus.req) && (w_win > r_id);

   always_comb begin
      w_state_nxt = r_state;
      w_id_nxt    = r_id;
      w_idx_nxt   = r_idx;
      w_ms_nxt    = r_ms;
      w_dur_nxt   = r_dur;
      w_freq_nxt  = r_freq;
      w_nv_nxt    = r_nv;
      w_busy_nxt  = r_busy;
      w_done_nxt  = 1'b0;

      if (w_preempt) begin
         w_state_nxt = S_LOAD;
         w_id_nxt    = w_win;
         w_idx_nxt   = 2'd0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (|bus.req) begin
                  w_state_nxt = S_LOAD;
                  w_id_nxt    = w_win;
                  w_idx_nxt   = 2'd0;
                  w_busy_nxt  = 1'b1;
               end
            end
            S_LOAD: begin
               w_freq_nxt  = w_rom_freq;
               w_nv_nxt    = 1'b1;
               w_ms_nxt    = '0;
               w_dur_nxt   = '0;
               w_state_nxt = S_PLAY;
            end
            S_PLAY: begin
               if (r_ms == c_MS_LAST) begin
                  w_ms_nxt  = '0;
                  w_dur_nxt = w_dur_inc;
                  if (w_dur_inc == w_rom_dur) begin
                     if (r_idx == w_last_idx) begin
                        w_state_nxt = S_IDLE;
                        w_freq_nxt  = c_SILENT;
                        w_nv_nxt    = 1'b0;
                        w_busy_nxt  = 1'b0;
                        w_done_nxt  = 1'b1;
                     end else begin
                        w_idx_nxt   = r_idx + 2'd1;
                        w_state_nxt = S_LOAD;
                     end
                  end
               end else begin
                  w_ms_nxt = r_ms + c_MSW'(1);
               end
            end
            default: begin
               w_state_nxt = S_IDLE;
            end
         endcase
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state <= S_IDLE;
         r_id    <= 2'd0;
         r_idx   <= 2'd0;
         r_ms    <= '0;
         r_dur   <= '0;
         r_freq  <= c_SILENT;
         r_nv    <= 1'b0;
         r_busy  <= 1'b0;
         r_done  <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         r_id    <= w_id_nxt;
         r_idx   <= w_idx_nxt;
         r_ms    <= w_ms_nxt;
         r_dur   <= w_dur_nxt;
         r_freq  <= w_freq_nxt;
         r_nv    <= w_nv_nxt;
         r_busy  <= w_busy_nxt;
         r_done  <= w_done_nxt;
      end
   end

   assign bus.freq       = r_freq;
   assign bus.note_valid = r_nv;
   assign bus.busy       = r_busy;
   assign bus.active_id  = r_id;
   assign bus.done       = r_done;

endmodule
`default_nettype wire

// File: tb/tb_sfx_scheduler.sv
`default_nettype none
// =============================================================================
// Module  : tb_sfx_scheduler
// Brief   : Self-checking bench for sfx_scheduler with a timeline-based model.
// Rev     : 1.0  initial release
// =============================================================================
module tb_sfx_scheduler;

   localparam int c_MS     = 4;
   localparam int c_SILENT = 20000;

   logic clk = 1'b0;
   logic reset = 1'b1;
   always #5 clk = ~clk;

   sfx_scheduler_if bus();

   sfx_scheduler #(.MS_CYCLES(c_MS), .SILENT_FREQ(c_SILENT)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   int n_checks = 0;
   int n_errors = 0;

   // Sequence tables straight from the note list.
   int c_nnotes [3] = '{2, 2, 4};
   int c_freq   [3][4] = '{'{1048, 1318, 0, 0}, '{392, 262, 0, 0}, '{523, 392, 330, 262}};
   int c_dur    [3][4] = '{'{100, 100, 0, 0}, '{150, 250, 0, 0}, '{300, 300, 300, 300}};

   // Model state: a sequence is a timeline measured from its acceptance edge.
   int          m_t = 0;
   int          m_start = 0;
   logic [31:0] m_freq = 32'(c_SILENT);
   logic        m_nv = 1'b0;
   logic        m_busy = 1'b0;
   logic [1:0]  m_id = 2'd0;
   logic        m_done = 1'b0;

   function automatic int seq_total(input int id);
      int s = 0;
      for (int j = 0; j < c_nnotes[id]; j++) s += 1 + c_dur[id][j] * c_MS;
      return s;
   endfunction

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at t=%0t", name, act, act, exp, exp, $time);
      end
   endtask

   task automatic model_edge(input logic [2:0] r);
      int w, el, acc;
      m_t++;
      w = r[2] ? 2 : (r[1] ? 1 : 0);
      if (r != 3'b000 && (!m_busy || w > int'(m_id))) begin
         m_busy  = 1'b1;
         m_id    = 2'(w);
         m_start = m_t;
         m_done  = 1'b0;
      end else if (m_busy) begin
         el = m_t - m_start;
         m_done = 1'b0;
         if (el == seq_total(m_id)) begin
            m_busy = 1'b0;
            m_done = 1'b1;
            m_freq = 32'(c_SILENT);
            m_nv   = 1'b0;
         end else if (el >= 1) begin
            acc = 1;
            for (int j = 0; j < c_nnotes[m_id]; j++) begin
               if (el >= acc) m_freq = 32'(c_freq[m_id][j]);
               acc += 1 + c_dur[m_id][j] * c_MS;
            end
            m_nv = 1'b1;
         end
      end else begin
         m_done = 1'b0;
      end
   endtask

   task automatic model_reset();
      m_busy = 1'b0;
      m_done = 1'b0;
      m_nv   = 1'b0;
      m_id   = 2'd0;
      m_freq = 32'(c_SILENT);
   endtask

   // One clock: drive req, let the edge happen, then compare against the model.
   task automatic tick(input logic [2:0] r);
      bus.req = r;
      @(posedge clk);
      model_edge(r);
      #1;
      bus.req = 3'b000;
      chk("cycle", {bus.freq, bus.note_valid, bus.busy, bus.active_id, bus.done},
                   {m_freq, m_nv, m_busy, m_id, m_done});
   endtask

   typedef struct {
      logic [2:0] req;
      logic [1:0] exp_id;
      int         exp_f0;
      int         exp_total;
   } vec_t;

   vec_t vecs [7];
   int   n, dones;

   initial begin
      vecs[0] = '{3'b001, 2'd0, 1048, 802};
      vecs[1] = '{3'b010, 2'd1, 392, 1602};
      vecs[2] = '{3'b100, 2'd2, 523, 4804};
      vecs[3] = '{3'b011, 2'd1, 392, 1602};
      vecs[4] = '{3'b110, 2'd2, 523, 4804};
      vecs[5] = '{3'b111, 2'd2, 523, 4804};
      vecs[6] = '{3'b101, 2'd2, 523, 4804};

      bus.req = 3'b000;
      #23;
      chk("reset_freq", bus.freq, 64'(c_SILENT));
      chk("reset_busy", bus.busy, 0);
      reset = 1'b0;
      for (int i = 0; i < 50; i++) tick(3'b000);
      chk("idle_freq", bus.freq, 64'(c_SILENT));
      chk("idle_nv", bus.note_valid, 0);
      chk("idle_done", bus.done, 0);

      // Hit, cycle-exact profile
      tick(3'b001);
      chk("hit_busy", bus.busy, 1);
      chk("hit_id", bus.active_id, 0);
      tick(3'b000);
      chk("hit_f0", bus.freq, 1048);
      n = 1;
      while (bus.freq == 32'd1048 && n < 1000) begin tick(3'b000); if (bus.freq == 32'd1048) n++; end
      chk("hit_len1048", n, 401);
      n = 0;
      while (bus.freq == 32'd1318 && n < 1000) begin n++; tick(3'b000); end
      chk("hit_len1318", n, 400);
      chk("hit_done", bus.done, 1);
      tick(3'b000);
      chk("hit_done_1cyc", bus.done, 0);

      // Table-driven sequences from idle
      for (int v = 0; v < 7; v++) begin
         tick(vecs[v].req);
         chk("vec_id", bus.active_id, vecs[v].exp_id);
         chk("vec_busy", bus.busy, 1);
         tick(3'b000);
         chk("vec_f0", bus.freq, 64'(vecs[v].exp_f0));
         n = 1;
         while (!bus.done && n < vecs[v].exp_total + 20) begin tick(3'b000); n++; end
         chk("vec_total", n, 64'(vecs[v].exp_total));
         for (int i = 0; i < 10; i++) tick(3'b000);
         chk("vec_idle", bus.busy, 0);
      end

      // Preemption: game-over 50 cycles into a hit
      tick(3'b001);
      for (int i = 0; i < 49; i++) tick(3'b000);
      tick(3'b100);
      chk("pre_id", bus.active_id, 2);
      chk("pre_hold", bus.freq, 1048);
      tick(3'b000);
      chk("pre_f0", bus.freq, 523);
      dones = 0;
      n = 1;
      while (bus.busy && n < 6000) begin tick(3'b000); n++; if (bus.done) dones++; end
      chk("pre_total", n, 4804);
      chk("pre_dones", dones, 1);
      for (int i = 0; i < 10; i++) tick(3'b000);

      // Drop: lower-priority requests during game-over
      tick(3'b100);
      for (int i = 0; i < 500; i++) tick(3'b000);
      tick(3'b001);
      for (int i = 0; i < 300; i++) tick(3'b000);
      tick(3'b010);
      chk("drop_id", bus.active_id, 2);
      n = 802;
      while (!bus.done && n < 6000) begin tick(3'b000); n++; end
      chk("drop_total", n, 4804);
      for (int i = 0; i < 30; i++) tick(3'b000);
      chk("drop_idle_freq", bus.freq, 64'(c_SILENT));

      // Reset mid-note during miss note 2
      tick(3'b010);
      for (int i = 0; i < 700; i++) tick(3'b000);
      chk("rst_pre_freq", bus.freq, 262);
      #2 reset = 1'b1;
      #1;
      model_reset();
      chk("rst_freq", bus.freq, 64'(c_SILENT));
      chk("rst_nv", bus.note_valid, 0);
      chk("rst_busy", bus.busy, 0);
      chk("rst_id", bus.active_id, 0);
      chk("rst_done", bus.done, 0);
      @(posedge clk);
      m_t++;
      #3 reset = 1'b0;
      dones = 0;
      for (int i = 0; i < 30; i++) begin tick(3'b000); if (bus.done) dones++; end
      chk("rst_no_done", dones, 0);

      // Randomized traffic against the model
      for (int i = 0; i < 4000; i++) begin
         if ($urandom_range(0, 149) == 0) tick(3'($urandom_range(1, 7)));
         else tick(3'b000);
      end

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

   initial begin
      #5_000_000;
      $display("FAIL timeout: simulation did not finish, got running expected finished");
      $fatal(1);
   end

endmodule
`default_nettype wire
